// File: rtl/stage_sequencer_if.sv
// Handshake and status bundle between the Pillar stage sequencer and its surroundings.
// The master side drives the control/ready inputs; the sequencer connects as the slave.
interface stage_sequencer_if #(
  parameter int unsigned CNT_W = 32
);
  logic             start_i;
  logic             halt_i;
  logic             stall_i;
  logic [31:0]      ir_i;
  logic             imem_ready_i;
  logic             dmem_ready_i;
  logic             imem_req_o;
  logic             ir_load_o;
  logic             dmem_req_o;
  logic             dmem_we_o;
  logic [2:0]       stage_o;
  logic             wd_q_readin_o;
  logic             busy_o;
  logic             fault_o;
  logic [CNT_W-1:0] retired_o;

  modport master (
    output start_i, halt_i, stall_i, ir_i, imem_ready_i, dmem_ready_i,
    input  imem_req_o, ir_load_o, dmem_req_o, dmem_we_o, stage_o,
           wd_q_readin_o, busy_o, fault_o, retired_o
  );

  modport slave (
    input  start_i, halt_i, stall_i, ir_i, imem_ready_i, dmem_ready_i,
    output imem_req_o, ir_load_o, dmem_req_o, dmem_we_o, stage_o,
           wd_q_readin_o, busy_o, fault_o, retired_o
  );
endinterface

// File: rtl/stage_sequencer.sv
// Multi-cycle stage sequencer for the Pillar core: FETCH, DECODE, EXECUTE, optional MEMORY,
// WRITEBACK, with memory handshakes, stall/halt, a sticky bus-timeout fault and a retire count.
module stage_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic               clk,
  input  logic               reset,
  stage_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_FAULT     = 3'd7
  } state_t;

  localparam int unsigned      WAIT_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam bit               TIMEOUT_EN = (MEM_TIMEOUT != 0);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  state_t            state_q;
  logic [WAIT_W-1:0] wait_q;
  logic [CNT_W-1:0]  retired_q;
  logic              store_q;

  logic [6:0] opcode;
  logic       op_is_load;
  logic       op_is_store;
  logic       wait_expired;

  always_comb begin
    opcode       = bus.ir_i[6:0];
    op_is_load   = (opcode == OP_LOAD);
    op_is_store  = (opcode == OP_STORE);
    wait_expired = TIMEOUT_EN && (wait_q == WAIT_LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      retired_q <= '0;
      store_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start_i) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
          end
        end
        // Ready in the last permitted wait cycle takes priority over the timeout.
        S_FETCH: begin
          if (bus.imem_ready_i) begin
            state_q <= S_DECODE;
          end else if (wait_expired) begin
            state_q <= S_FAULT;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_DECODE: begin
          if (!bus.stall_i) state_q <= S_EXECUTE;
        end
        S_EXECUTE: begin
          if (!bus.stall_i) begin
            if (op_is_load || op_is_store) begin
              state_q <= S_MEMORY;
              wait_q  <= '0;
              store_q <= op_is_store;
            end else begin
              state_q <= S_WRITEBACK;
            end
          end
        end
        S_MEMORY: begin
          if (bus.dmem_ready_i) begin
            state_q <= S_WRITEBACK;
          end else if (wait_expired) begin
            state_q <= S_FAULT;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_WRITEBACK: begin
          if (!bus.stall_i) begin
            retired_q <= retired_q + 1'b1;
            if (bus.halt_i) begin
              state_q <= S_IDLE;
            end else begin
              state_q <= S_FETCH;
              wait_q  <= '0;
            end
          end
        end
        S_FAULT: state_q <= S_FAULT;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.stage_o       = state_q;
    bus.imem_req_o    = (state_q == S_FETCH);
    bus.ir_load_o     = (state_q == S_FETCH) && bus.imem_ready_i;
    bus.dmem_req_o    = (state_q == S_MEMORY);
    bus.dmem_we_o     = (state_q == S_MEMORY) && store_q;
    bus.wd_q_readin_o = (state_q == S_WRITEBACK) && !bus.stall_i;
    bus.busy_o        = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                        (state_q == S_EXECUTE) || (state_q == S_MEMORY) ||
                        (state_q == S_WRITEBACK);
    bus.fault_o       = (state_q == S_FAULT);
    bus.retired_o     = retired_q;
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: each instruction is described by its wait/stall profile,
// the expected stage schedule is laid out from that profile and checked every cycle.
module tb_stage_sequencer;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_LW   = 32'h0000A103;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_ADDI = 32'h00100093;

  typedef struct {
    logic [2:0] stage;
    logic       imem_req;
    logic       ir_load;
    logic       dmem_req;
    logic       dmem_we;
    logic       wd;
    logic       busy;
    logic       fault;
    logic [3:0] retired;
  } exp_t;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   m_retired;
  exp_t exp_q[$];
  exp_t cmp_e;

  stage_sequencer_if #(.CNT_W(4)) bus ();

  stage_sequencer #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: one expectation per cycle, sampled mid-low-phase.
  always @(negedge clk) begin
    #2;
    if (exp_q.size() != 0) begin
      cmp_e = exp_q.pop_front();
      chk("stage",       32'(bus.stage_o),       32'(cmp_e.stage));
      chk("imem_req",    32'(bus.imem_req_o),    32'(cmp_e.imem_req));
      chk("ir_load",     32'(bus.ir_load_o),     32'(cmp_e.ir_load));
      chk("dmem_req",    32'(bus.dmem_req_o),    32'(cmp_e.dmem_req));
      chk("dmem_we",     32'(bus.dmem_we_o),     32'(cmp_e.dmem_we));
      chk("wd_q_readin", 32'(bus.wd_q_readin_o), 32'(cmp_e.wd));
      chk("busy",        32'(bus.busy_o),        32'(cmp_e.busy));
      chk("fault",       32'(bus.fault_o),       32'(cmp_e.fault));
      chk("retired",     32'(bus.retired_o),     32'(cmp_e.retired));
    end
  end

  // Drive one cycle of inputs and record what the outputs must be for the given stage.
  task automatic step(input logic rst_n, input logic st, input logic hl, input logic sl,
                      input logic [31:0] ir, input logic imr, input logic dmr,
                      input int es, input logic is_store);
    exp_t e;
    @(negedge clk);
    reset            = rst_n;
    bus.start_i      = st;
    bus.halt_i       = hl;
    bus.stall_i      = sl;
    bus.ir_i         = ir;
    bus.imem_ready_i = imr;
    bus.dmem_ready_i = dmr;
    if (!rst_n) m_retired = 0;
    e.stage    = 3'(es);
    e.imem_req = (es == 1);
    e.ir_load  = (es == 1) && imr;
    e.dmem_req = (es == 4);
    e.dmem_we  = (es == 4) && is_store;
    e.wd       = (es == 5) && !sl;
    e.busy     = (es >= 1) && (es <= 5);
    e.fault    = (es == 7);
    e.retired  = 4'(m_retired);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, I_ADD, 0, 0, 0, 0);
  endtask

  task automatic start_pulse();
    step(1, 1, 0, 0, I_ADD, 0, 0, 0, 0);
  endtask

  // fw/mw: not-ready cycles before ready; ds/es_n/ws: stall cycles in DECODE/EXECUTE/WRITEBACK.
  task automatic run_instr(input logic [31:0] ir, input int fw, input int mw,
                           input int ds, input int es_n, input int ws, input logic hlt);
    logic st_op;
    logic mem_op;
    st_op  = (ir[6:0] == 7'b0100011);
    mem_op = st_op || (ir[6:0] == 7'b0000011);
    for (int i = 0; i <= fw; i++)   step(1, 0, 0, 1, ir, (i == fw), 1, 1, st_op);
    for (int i = 0; i <= ds; i++)   step(1, 0, 1, (i < ds), ir, 0, 0, 2, st_op);
    for (int i = 0; i <= es_n; i++) step(1, 1, 0, (i < es_n), ir, 1, 0, 3, st_op);
    if (mem_op)
      for (int i = 0; i <= mw; i++) step(1, 0, 0, 1, ir, 0, (i == mw), 4, st_op);
    for (int i = 0; i <= ws; i++)   step(1, 0, hlt, (i < ws), ir, 0, 0, 5, st_op);
    m_retired = (m_retired + 1) % 16;
  endtask

  logic [31:0] ops [4];

  initial begin
    errors = 0;
    checks = 0;
    m_retired = 0;
    reset = 1'b0;
    bus.start_i = 1'b0;
    bus.halt_i = 1'b0;
    bus.stall_i = 1'b0;
    bus.ir_i = '0;
    bus.imem_ready_i = 1'b0;
    bus.dmem_ready_i = 1'b0;
    ops[0] = I_ADD; ops[1] = I_LW; ops[2] = I_ADDI; ops[3] = I_SW;

    // Reset holds everything at zero even with start asserted.
    step(0, 1, 0, 0, I_ADD, 1, 1, 0, 0);
    #3 chk("reset_stage_lit", 32'(bus.stage_o), 0);
    step(0, 1, 0, 0, I_ADD, 1, 1, 0, 0);
    idle(2);

    // Single ADD with halt, then retired count must read 1.
    start_pulse();
    run_instr(I_ADD, 0, 0, 0, 0, 0, 1);
    #3 chk("add_wb_stage_lit", 32'(bus.stage_o), 5);
    chk("add_wb_strobe_lit", 32'(bus.wd_q_readin_o), 1);
    idle(1);
    #3 chk("add_retired_lit", 32'(bus.retired_o), 1);
    chk("add_idle_busy_lit", 32'(bus.busy_o), 0);

    // Back-to-back mix: memory waits, store, stalls, late fetch ready, stalled halt.
    start_pulse();
    run_instr(I_ADD,  0, 0, 0, 0, 0, 0);
    run_instr(I_LW,   1, 2, 0, 0, 0, 0);
    run_instr(I_SW,   0, 0, 0, 0, 0, 0);
    run_instr(I_ADD,  0, 0, 1, 2, 0, 0);
    run_instr(I_ADDI, 3, 0, 0, 0, 0, 0);
    run_instr(I_ADD,  0, 0, 0, 0, 2, 1);
    idle(2);
    #3 chk("mix_retired_lit", 32'(bus.retired_o), 7);

    // Eleven more instructions: 18 retirements wrap a 4-bit counter to 2.
    start_pulse();
    for (int i = 0; i < 11; i++) run_instr(ops[i % 4], i % 2, i % 3, 0, 0, 0, (i == 10));
    idle(1);
    #3 chk("wrap_retired_lit", 32'(bus.retired_o), 2);

    // Asynchronous reset in MEMORY drops the request at once.
    start_pulse();
    step(1, 0, 0, 0, I_LW, 1, 0, 1, 0);
    step(1, 0, 0, 0, I_LW, 0, 0, 2, 0);
    step(1, 0, 0, 0, I_LW, 0, 0, 3, 0);
    step(1, 0, 0, 0, I_LW, 0, 0, 4, 0);
    #3 chk("mem_req_before_rst_lit", 32'(bus.dmem_req_o), 1);
    step(0, 0, 0, 0, I_LW, 0, 0, 0, 0);
    #1 chk("mem_req_in_rst_lit", 32'(bus.dmem_req_o), 0);
    chk("retired_in_rst_lit", 32'(bus.retired_o), 0);
    idle(3);
    start_pulse();
    run_instr(I_ADD, 0, 0, 0, 0, 0, 1);
    idle(1);

    // Fetch timeout: four not-ready cycles, then FAULT ignoring start.
    start_pulse();
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, I_ADD, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, I_ADD, 1, 1, 7, 0);
    #3 chk("fetch_fault_lit", 32'(bus.fault_o), 1);
    chk("fetch_fault_stage_lit", 32'(bus.stage_o), 7);
    step(0, 0, 0, 0, I_ADD, 0, 0, 0, 0);
    idle(1);

    // Memory timeout on a load.
    start_pulse();
    step(1, 0, 0, 0, I_LW, 1, 0, 1, 0);
    step(1, 0, 0, 0, I_LW, 0, 0, 2, 0);
    step(1, 0, 0, 0, I_LW, 0, 0, 3, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, I_LW, 0, 0, 4, 0);
    for (int i = 0; i < 2; i++) step(1, 1, 0, 0, I_LW, 1, 1, 7, 0);
    step(0, 0, 0, 0, I_ADD, 0, 0, 0, 0);
    idle(1);
    start_pulse();
    run_instr(I_SW, 0, 0, 0, 0, 0, 1);
    idle(2);

    @(negedge clk);
    #5;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
